// File: rtl/spi_slave_uc_if.sv
// Pin and data-handshake bundle for the SPI mode-0 slave transceiver.
// RX side: a word moves to the consumer on any cycle where RX_VALID and RX_ACK are both high;
// TX side: TX_ACK pulses for one cycle after the slave has taken TX_DATA (show-ahead read strobe).
interface spi_slave_uc_if #(
   parameter int inBits = 16
);
   logic              SCK;
   logic              CSbar;
   logic              MOSI;
   logic              MISO;
   logic              MISO_OE;
   logic [inBits-1:0] TX_DATA;
   logic              TX_ACK;
   logic [inBits-1:0] RX_DATA;
   logic              RX_VALID;
   logic              RX_ACK;
   logic              BUSY;
   logic              OVERRUN;
   logic              FRAME_ERR;
   logic              ERR_CLR;
   logic              STATE_DBG;

   modport slave (
      input  SCK, CSbar, MOSI, TX_DATA, RX_ACK, ERR_CLR,
      output MISO, MISO_OE, TX_ACK, RX_DATA, RX_VALID, BUSY, OVERRUN, FRAME_ERR, STATE_DBG
   );

   modport master (
      output SCK, CSbar, MOSI, TX_DATA, RX_ACK, ERR_CLR,
      input  MISO, MISO_OE, TX_ACK, RX_DATA, RX_VALID, BUSY, OVERRUN, FRAME_ERR, STATE_DBG
   );
endinterface

// File: rtl/spi_slave_uc.sv
// SPI mode-0 slave: all pins are oversampled in the CLK_65 domain, words are MSB first,
// received words are held for a consumer and transmit words are pulled from a show-ahead FIFO.
module spi_slave_uc #(
   parameter int inBits = 16
) (
   input  logic           CLK_65,
   input  logic           RST,
   spi_slave_uc_if.slave  bus
);
   localparam int CW = (inBits > 2) ? $clog2(inBits) : 1;
   localparam logic [CW-1:0] LAST = CW'(inBits - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state_q;
   logic [2:0]        sck_q;
   logic [2:0]        cs_q;
   logic [1:0]        mosi_q;
   logic              armed_q;
   logic [CW-1:0]     bit_cnt_q;
   logic [inBits-2:0] rx_shift_q;
   logic [inBits-1:0] tx_shift_q;
   logic [inBits-1:0] rx_data_q;
   logic              rx_valid_q;
   logic              tx_ack_q;
   logic              ovr_q;
   logic              ferr_q;

   logic              sck_rise;
   logic              sck_fall;
   logic              cs_rise;
   logic              cs_fall;
   logic              busy;
   logic [inBits-1:0] rx_word_d;

   // Index 1 is the synchronized level, index 2 the previous one used for edge detection.
   assign sck_rise  = sck_q[1] & ~sck_q[2];
   assign sck_fall  = ~sck_q[1] & sck_q[2];
   assign cs_rise   = cs_q[1] & ~cs_q[2];
   assign cs_fall   = ~cs_q[1] & cs_q[2];
   assign rx_word_d = {rx_shift_q, mosi_q[1]};
   assign busy      = armed_q & ~cs_q[1];

   always_ff @(posedge CLK_65) begin
      if (RST) begin
         state_q    <= IDLE;
         sck_q      <= '0;
         cs_q       <= '0;
         mosi_q     <= '0;
         armed_q    <= 1'b0;
         bit_cnt_q  <= '0;
         rx_shift_q <= '0;
         tx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         tx_ack_q   <= 1'b0;
         ovr_q      <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         sck_q    <= {sck_q[1:0], bus.SCK};
         cs_q     <= {cs_q[1:0], bus.CSbar};
         mosi_q   <= {mosi_q[0], bus.MOSI};
         tx_ack_q <= 1'b0;
         // A frame may only start after CS has been seen deasserted since reset.
         if (cs_q[1]) armed_q <= 1'b1;
         if (bus.ERR_CLR) begin
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
         end
         if (bus.RX_ACK) rx_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cs_fall && armed_q) begin
                  state_q    <= SHIFT;
                  tx_shift_q <= bus.TX_DATA;
                  tx_ack_q   <= 1'b1;
                  bit_cnt_q  <= '0;
               end
            end
            SHIFT: begin
               if (cs_rise) begin
                  if (bit_cnt_q != '0) ferr_q <= 1'b1;
                  bit_cnt_q <= '0;
                  state_q   <= IDLE;
               end else begin
                  if (sck_rise) begin
                     rx_shift_q <= rx_word_d[inBits-2:0];
                     if (bit_cnt_q == LAST) begin
                        bit_cnt_q <= '0;
                        // A simultaneous acknowledge frees the holding register for this word.
                        if (!rx_valid_q || bus.RX_ACK) begin
                           rx_data_q  <= rx_word_d;
                           rx_valid_q <= 1'b1;
                        end else begin
                           ovr_q <= 1'b1;
                        end
                     end else begin
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                     end
                  end
                  if (sck_fall) begin
                     if (bit_cnt_q == '0) begin
                        tx_shift_q <= bus.TX_DATA;
                        tx_ack_q   <= 1'b1;
                     end else begin
                        tx_shift_q <= {tx_shift_q[inBits-2:0], 1'b0};
                     end
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.BUSY      = busy;
   assign bus.MISO_OE   = busy;
   assign bus.MISO      = busy & tx_shift_q[inBits-1];
   assign bus.TX_ACK    = tx_ack_q;
   assign bus.RX_DATA   = rx_data_q;
   assign bus.RX_VALID  = rx_valid_q;
   assign bus.OVERRUN   = ovr_q;
   assign bus.FRAME_ERR = ferr_q;
   assign bus.STATE_DBG = (state_q == SHIFT);
endmodule

// File: tb/tb_spi_slave_uc.sv
// Bench for spi_slave_uc: an SPI master driver, a pin-level behavioural model that schedules
// the expected output changes three clock edges after each pin event, and literal spot checks.
module tb_spi_slave_uc;
   localparam int W = 16;
   localparam int EV_BUSY1 = 0;
   localparam int EV_BUSY0 = 1;
   localparam int EV_TXACK = 2;
   localparam int EV_WORD  = 3;
   localparam int EV_FERR  = 4;

   typedef struct {
      int           due;
      int           kind;
      logic [W-1:0] val;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_slave_uc_if #(.inBits(W)) bus ();
   spi_slave_uc #(.inBits(W)) dut (.CLK_65(clk), .RST(rst), .bus(bus.slave));

   int total = 0;
   int bad = 0;
   int cyc = 0;
   ev_t ev_q[$];
   logic [W-1:0] exp_q[$];

   logic         m_busy = 0, m_txack = 0, m_valid = 0, m_ovr = 0, m_ferr = 0;
   logic [W-1:0] m_data = '0;
   logic [W-1:0] m_word = '0;
   logic         m_armed = 0, m_in_frame = 0;
   int           m_bits = 0;
   logic         ack_req = 0, clr_req = 0, auto_ack = 0, prev_valid = 0;
   int           dut_ack_cnt = 0, valid_rise_cyc = -1, last_rise_cyc = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_ev(input int due, input int kind, input logic [W-1:0] val);
      ev_t e;
      e.due = due; e.kind = kind; e.val = val;
      ev_q.push_back(e);
   endtask

   // Advance the model to the outputs produced by the posedge just taken, then compare.
   task automatic model_step();
      logic got_word;
      logic [W-1:0] wv;
      got_word = 0;
      wv = '0;
      m_txack = 0;
      if (rst) begin
         m_busy = 0; m_valid = 0; m_data = '0; m_ovr = 0; m_ferr = 0;
         m_armed = 0; m_in_frame = 0;
         ev_q.delete();
      end else begin
         if (bus.CSbar) m_armed = 1;
         if (bus.ERR_CLR) begin
            m_ovr = 0;
            m_ferr = 0;
         end
         for (int i = ev_q.size() - 1; i >= 0; i--) begin
            if (ev_q[i].due == cyc) begin
               case (ev_q[i].kind)
                  EV_BUSY1: m_busy = 1;
                  EV_BUSY0: m_busy = 0;
                  EV_TXACK: m_txack = 1;
                  EV_FERR:  m_ferr = 1;
                  default: begin got_word = 1; wv = ev_q[i].val; end
               endcase
               ev_q.delete(i);
            end
         end
         if (got_word) begin
            if (!m_valid || bus.RX_ACK) begin
               m_data = wv;
               m_valid = 1;
            end else begin
               m_ovr = 1;
            end
         end else if (bus.RX_ACK) begin
            m_valid = 0;
         end
      end
      if (m_txack) begin
         exp_q.push_back(bus.TX_DATA);
         bus.TX_DATA = W'($urandom);
      end
      chk1("busy", bus.BUSY, m_busy);
      chk1("miso_oe", bus.MISO_OE, m_busy);
      chk1("tx_ack", bus.TX_ACK, m_txack);
      chk1("rx_valid", bus.RX_VALID, m_valid);
      chkw("rx_data", bus.RX_DATA, m_data);
      chk1("overrun", bus.OVERRUN, m_ovr);
      chk1("frame_err", bus.FRAME_ERR, m_ferr);
      if (!m_busy) chk1("miso_idle", bus.MISO, 1'b0);
      if (bus.TX_ACK === 1'b1) dut_ack_cnt++;
      if (bus.RX_VALID === 1'b1 && !prev_valid) valid_rise_cyc = cyc;
      prev_valid = (bus.RX_VALID === 1'b1);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
      cyc++;
      model_step();
      @(negedge clk);
      bus.RX_ACK = ack_req | (auto_ack && bus.RX_VALID === 1'b1 && $urandom_range(0, 3) == 0);
      ack_req = 0;
      bus.ERR_CLR = clr_req;
      clr_req = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic cs_low();
      bus.CSbar = 0;
      if (m_armed && !m_in_frame) begin
         m_in_frame = 1;
         m_bits = 0;
         push_ev(cyc + 2, EV_BUSY1, '0);
         push_ev(cyc + 3, EV_TXACK, '0);
      end
   endtask

   task automatic cs_high();
      bus.CSbar = 1;
      if (m_in_frame) begin
         push_ev(cyc + 2, EV_BUSY0, '0);
         if (m_bits % W != 0) push_ev(cyc + 3, EV_FERR, '0);
         m_in_frame = 0;
      end
   endtask

   // Clock n bits of data out MSB first; MISO is read just before each rising edge.
   task automatic send_bits(input logic [W-1:0] data, input int n, input logic ack_last,
                            output logic [W-1:0] miso_word);
      logic         in_f;
      logic [W-1:0] exp;
      in_f = m_in_frame;
      exp = '0;
      miso_word = '0;
      for (int b = 0; b < n; b++) begin
         bus.MOSI = data[W-1-b];
         repeat (5) tick();
         if (b == 0) exp = (exp_q.size() > 0) ? exp_q[$] : '0;
         miso_word = {miso_word[W-2:0], bus.MISO};
         bus.SCK = 1;
         last_rise_cyc = cyc;
         if (m_in_frame) begin
            m_bits++;
            m_word = {m_word[W-2:0], data[W-1-b]};
            if (m_bits % W == 0) push_ev(cyc + 3, EV_WORD, m_word);
         end
         for (int k = 0; k < 5; k++) begin
            if (ack_last && b == n - 1 && k == 1) ack_req = 1;
            tick();
         end
         bus.SCK = 0;
         if (m_in_frame && m_bits > 0 && m_bits % W == 0) push_ev(cyc + 3, EV_TXACK, '0);
      end
      if (in_f && m_in_frame && n == W) chkw("miso_word", miso_word, exp);
   endtask

   task automatic one_frame(input logic [W-1:0] d, output logic [W-1:0] mw);
      cs_low();
      idle(5);
      send_bits(d, W, 1'b0, mw);
      idle(5);
      cs_high();
      idle(5);
   endtask

   logic [W-1:0] mw;
   int a0;

   initial begin
      bus.SCK = 0; bus.CSbar = 1; bus.MOSI = 0; bus.TX_DATA = '0;
      bus.RX_ACK = 0; bus.ERR_CLR = 0;
      idle(3);
      chk1("rst_busy", bus.BUSY, 1'b0);
      chk1("rst_miso", bus.MISO, 1'b0);
      chkw("rst_rx_data", bus.RX_DATA, 16'h0000);
      chk1("rst_rx_valid", bus.RX_VALID, 1'b0);
      chk1("rst_tx_ack", bus.TX_ACK, 1'b0);
      rst = 0;
      idle(6);

      // Single frame with known data.
      bus.TX_DATA = 16'h1234;
      a0 = dut_ack_cnt;
      cs_low();
      idle(3);
      chk1("t1_ack_at_cs_fall", bus.TX_ACK, 1'b1);
      chki("t1_ack_count_cs", dut_ack_cnt - a0, 1);
      idle(2);
      send_bits(16'hA5C3, W, 1'b0, mw);
      chkw("t1_miso_word", mw, 16'h1234);
      idle(5);
      chkw("t1_rx_data", bus.RX_DATA, 16'hA5C3);
      chk1("t1_rx_valid", bus.RX_VALID, 1'b1);
      chki("t1_valid_latency", valid_rise_cyc - last_rise_cyc, 3);
      chk1("t1_overrun", bus.OVERRUN, 1'b0);
      chk1("t1_frame_err", bus.FRAME_ERR, 1'b0);
      chk1("t1_state_shift", bus.STATE_DBG, 1'b1);
      cs_high();
      idle(5);
      chk1("t1_state_idle", bus.STATE_DBG, 1'b0);
      ack_req = 1;
      idle(2);

      // Two words in one frame, acknowledged between them.
      a0 = dut_ack_cnt;
      cs_low();
      idle(5);
      send_bits(16'h0001, W, 1'b0, mw);
      idle(3);
      chki("t2_ack_16th_fall", dut_ack_cnt - a0, 2);
      chkw("t2_word1", bus.RX_DATA, 16'h0001);
      ack_req = 1;
      tick();
      send_bits(16'hFFFF, W, 1'b0, mw);
      idle(5);
      chkw("t2_word2", bus.RX_DATA, 16'hFFFF);
      chk1("t2_valid2", bus.RX_VALID, 1'b1);
      ack_req = 1;
      tick();
      cs_high();
      idle(5);

      // Overrun, error clear, and acknowledge coincident with completion.
      cs_low();
      idle(5);
      send_bits(16'h1111, W, 1'b0, mw);
      send_bits(16'h2222, W, 1'b0, mw);
      idle(5);
      chkw("t3_kept_first", bus.RX_DATA, 16'h1111);
      chk1("t3_overrun_set", bus.OVERRUN, 1'b1);
      clr_req = 1;
      idle(2);
      chk1("t3_overrun_clr", bus.OVERRUN, 1'b0);
      send_bits(16'h3333, W, 1'b1, mw);
      idle(4);
      chkw("t3_ack_same_cycle_data", bus.RX_DATA, 16'h3333);
      chk1("t3_ack_same_cycle_ovr", bus.OVERRUN, 1'b0);
      chk1("t3_valid_kept", bus.RX_VALID, 1'b1);
      ack_req = 1;
      idle(2);
      chk1("t3_ack_clears", bus.RX_VALID, 1'b0);
      cs_high();
      idle(5);

      // CS released mid-word.
      cs_low();
      idle(5);
      send_bits(16'h5A5A, 9, 1'b0, mw);
      idle(5);
      cs_high();
      idle(5);
      chk1("t4_frame_err", bus.FRAME_ERR, 1'b1);
      chk1("t4_rx_valid", bus.RX_VALID, 1'b0);
      chk1("t4_busy", bus.BUSY, 1'b0);
      clr_req = 1;
      idle(2);
      one_frame(16'hC0DE, mw);
      chkw("t4_next_frame", bus.RX_DATA, 16'hC0DE);
      chk1("t4_ferr_cleared", bus.FRAME_ERR, 1'b0);
      ack_req = 1;
      idle(2);

      // Reset released while CS is already low.
      rst = 1;
      bus.CSbar = 0;
      idle(3);
      rst = 0;
      a0 = dut_ack_cnt;
      send_bits(16'hBEEF, W, 1'b0, mw);
      idle(5);
      chk1("t5_miso_oe", bus.MISO_OE, 1'b0);
      chki("t5_no_tx_ack", dut_ack_cnt - a0, 0);
      chk1("t5_no_rx_valid", bus.RX_VALID, 1'b0);
      cs_high();
      idle(5);
      one_frame(16'h1357, mw);
      chkw("t5_next_frame", bus.RX_DATA, 16'h1357);
      ack_req = 1;
      idle(2);

      // Reset pulsed after 7 bits.
      cs_low();
      idle(5);
      send_bits(16'hF0F0, 7, 1'b0, mw);
      rst = 1;
      tick();
      chk1("t6_busy", bus.BUSY, 1'b0);
      chk1("t6_miso_oe", bus.MISO_OE, 1'b0);
      chk1("t6_miso", bus.MISO, 1'b0);
      chk1("t6_tx_ack", bus.TX_ACK, 1'b0);
      chk1("t6_rx_valid", bus.RX_VALID, 1'b0);
      chkw("t6_rx_data", bus.RX_DATA, 16'h0000);
      chk1("t6_overrun", bus.OVERRUN, 1'b0);
      chk1("t6_frame_err", bus.FRAME_ERR, 1'b0);
      rst = 0;
      a0 = dut_ack_cnt;
      send_bits(16'hF0F0, 9, 1'b0, mw);
      idle(5);
      chk1("t6_ignored_busy", bus.BUSY, 1'b0);
      chk1("t6_ignored_valid", bus.RX_VALID, 1'b0);
      chki("t6_ignored_ack", dut_ack_cnt - a0, 0);
      cs_high();
      idle(5);
      one_frame(16'h2468, mw);
      chkw("t6_next_frame", bus.RX_DATA, 16'h2468);
      ack_req = 1;
      idle(2);

      // Randomized frames: word counts, data, acknowledge timing, partial last words.
      for (int f = 0; f < 12; f++) begin
         int nw;
         auto_ack = ($urandom_range(0, 1) == 1);
         nw = $urandom_range(1, 3);
         cs_low();
         idle(5);
         for (int w = 0; w < nw; w++) begin
            int n;
            n = (w == nw - 1 && $urandom_range(0, 5) == 0) ? $urandom_range(1, W - 1) : W;
            send_bits(W'($urandom), n, ($urandom_range(0, 3) == 0), mw);
            idle($urandom_range(0, 3));
         end
         idle(5);
         cs_high();
         idle(5);
         if ($urandom_range(0, 2) == 0) clr_req = 1;
      end
      auto_ack = 0;
      ack_req = 1;
      idle(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/spi_slave_uc.md
# spi_slave_uc

SPI mode-0 slave transceiver for the CLK_65 domain, the counterpart of the FPGA's SPI master link to the MBED. It receives words shifted in by an external master (MBED) on MOSI and presents them as a held word with a valid/acknowledge handshake. It simultaneously shifts out words popped from an upstream source (FIFO) on MISO. All pin inputs are asynchronous and are synchronized internally; no logic runs on SCK.

## Interface
- inBits, 16, word length in bits (≥2); MSB first in both directions.
- CLK_65  in  1  system clock, 65 MHz.
- RST  in  1  reset, synchronous, active-high.
- SCK  in  1  SPI clock from master, CPOL=0, asynchronous.
- CSbar  in  1  chip select from master, active-low, asynchronous.
- MOSI  in  1  serial data from master, asynchronous.
- MISO  out  1  serial data to master; 0 when not selected.
- MISO_OE  out  1  high while the slave is selected and armed (tri-state enable at the top level).
- TX_DATA  in  inBits  next word to transmit (FIFO q).
- TX_ACK  out  1  one-cycle pulse when TX_DATA is captured (drive FIFO rdreq).
- RX_DATA  out  inBits  last accepted received word.
- RX_VALID  out  1  high while RX_DATA holds an unacknowledged word.
- RX_ACK  in  1  consumer acknowledge; clears RX_VALID.
- BUSY  out  1  synchronized, armed chip-select asserted.
- OVERRUN  out  1  sticky: a word completed while RX_VALID was high.
- FRAME_ERR  out  1  sticky: CS released mid-word.
- ERR_CLR  in  1  clears OVERRUN and FRAME_ERR.

## Operation
- Synchronizers: SCK, CSbar and MOSI each pass through 2 flops (s1, s2). SCK and CSbar have a third flop (s3) for edge detection. Events are defined as follows:
  - rise = s2 & ~s3, fall = ~s2 & s3 on SCK.
  - cs_fall and cs_rise are the equivalent edges on CSbar.
  - MOSI s2 is sampled on the rise event.
- Reset values:
  - CSbar sync flops 0, SCK sync flops 0.
  - armed = 0.
  - bit_cnt, rx_shift, tx_shift, RX_DATA = 0.
  - All outputs = 0.
- Arming: armed sets when the synchronized CSbar is high, so a frame begins only at a genuine cs_fall. If CS is low while reset releases, that frame is ignored. BUSY = armed & ~CSbar_s2.
- States:
  - IDLE (CS high or not armed).
  - SHIFT (BUSY).
- IDLE -> SHIFT on cs_fall while armed:
  - tx_shift <= TX_DATA, TX_ACK pulse.
  - bit_cnt <= 0.
- In SHIFT, on rise:
  - rx_shift <= {rx_shift[inBits-2:0], MOSI_s2}.
  - bit_cnt increments. At inBits-1 -> word complete, and bit_cnt wraps to 0.
- Word complete:
  - If RX_VALID=0, or RX_ACK=1 in the same cycle: RX_DATA <= the shifted word and RX_VALID <= 1.
  - Otherwise the word is dropped, RX_DATA is unchanged and OVERRUN <= 1.
- In SHIFT, on fall:
  - If bit_cnt==0 (word boundary after a completed word): tx_shift <= TX_DATA, TX_ACK pulse.
  - Otherwise: tx_shift <= tx_shift << 1.
- Outputs: MISO = MISO_OE & tx_shift[inBits-1]; MISO_OE = BUSY.
- Multiple words per CS frame are supported without limit.
- On cs_rise:
  - If bit_cnt != 0: FRAME_ERR <= 1 and the partial word is discarded.
  - bit_cnt <= 0 and the block returns to IDLE.
- RX_ACK with RX_VALID=0 has no effect.
- ERR_CLR and a new error event in the same cycle: the flag stays set.
- RST mid-frame:
  - Abort immediately, all state returns to reset values.
  - No TX_ACK or RX_VALID for the interrupted word.
  - The block re-arms only after CS is seen high.

## Timing
- Pin-to-event latency: 2 CLK_65 edges. State updates on the 3rd CLK_65 edge after the first edge that samples the new pin level.
- RX_VALID rises exactly 3 CLK_65 cycles after the final SCK rising edge is first sampled.
- MISO changes 3 CLK_65 cycles after an SCK falling edge or a CS falling edge is first sampled.
- TX_ACK is high for exactly 1 cycle, coincident with the tx_shift load. TX_DATA must be valid in that same cycle (FIFO show-ahead q).
- Master requirements:
  - SCK high and low times ≥ 4 CLK_65 cycles (≥61.5 ns, SCK ≤ 8.1 MHz).
  - CS fall to first SCK rise ≥ 5 cycles.
  - Last SCK fall to CS rise ≥ 4 cycles.
  - CS high time ≥ 4 cycles.
- RX_VALID clears on the cycle after RX_ACK is sampled, unless a new word completes in that same cycle.

## Test plan
- Reset with CSbar=1, then send one 16-bit frame with MOSI 0xA5C3 and TX_DATA=0x1234:
  - One TX_ACK at the CS fall.
  - Master reads 0x1234 on MISO.
  - RX_DATA=0xA5C3, RX_VALID=1 exactly 3 cycles after the 16th SCK rise.
  - No error flags.
- Two words in one CS frame (0x0001, 0xFFFF) with RX_ACK after each:
  - Two RX_VALID events carrying the correct values.
  - TX_ACK pulses at the CS fall and at the 16th SCK fall.
  - Second MISO word equals TX_DATA at the second TX_ACK.
- Two words sent with no RX_ACK:
  - RX_DATA keeps the first word and OVERRUN=1.
  - ERR_CLR returns OVERRUN to 0.
  - RX_ACK in the same cycle as the second word's completion: no OVERRUN, and RX_DATA takes the second word.
- CS raised after 9 bits:
  - FRAME_ERR=1, RX_VALID stays 0, BUSY=0.
  - The next full frame is received correctly.
- Reset released while CSbar=0, SCK toggling:
  - MISO_OE=0, no TX_ACK, no RX_VALID.
  - After CS goes high then low, the next frame works.
- RST pulsed mid-word (after 7 bits):
  - All outputs 0 the next cycle.
  - The remaining SCK edges are ignored until a new CS fall.
